// File: rtl/oven_pkg.sv
// Shared definitions for the oven front-panel stage:
// FSM state encodings, hysteresis interval and setpoint defaults.
package oven_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] HYST          = 8'd10;
  localparam logic [7:0] TEMP_MIN_DEF  = 8'd10;
  localparam logic [7:0] TEMP_MAX_DEF  = 8'd245;
  localparam logic [7:0] TEMP_INIT_DEF = 8'd100;
  localparam logic [3:0] TIME_INIT_DEF = 4'd5;

endpackage

// File: rtl/oven_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
// Ports: clk, rst (async high), raw button in; level (debounced), press (1-cycle).
module oven_debounce #(
  parameter int DEBOUNCE = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips on the DEBOUNCE-th consecutive sample that differs from it;
  // any sample equal to the current level restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) lvl_d = s2_q;
      else                            cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      prev_q <= lvl_q;
      cnt_q  <= cnt_d;
    end
  end

  assign level = lvl_q;
  assign press = lvl_q & ~prev_q;

endmodule

// File: rtl/oven_setpoint_timer.sv
// Front-panel stage: debounced setpoint buttons and an IDLE/RUN/DONE cook timer.
// Ports: clk, rst, start, stop, 4 buttons in; set_temp, set_timer, timer, running, done out.
module oven_setpoint_timer
  import oven_pkg::*;
#(
  parameter int         TICK_DIV  = 50_000_000,
  parameter int         DEBOUNCE  = 500_000,
  parameter logic [7:0] TEMP_STEP = 8'd5,
  parameter logic [7:0] TEMP_MIN  = TEMP_MIN_DEF,
  parameter logic [7:0] TEMP_MAX  = TEMP_MAX_DEF,
  parameter logic [7:0] TEMP_INIT = TEMP_INIT_DEF,
  parameter logic [3:0] TIME_INIT = TIME_INIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       btn_temp_up,
  input  logic       btn_temp_down,
  input  logic       btn_time_up,
  input  logic       btn_time_down,
  output logic [7:0] set_temp,
  output logic [3:0] set_timer,
  output logic [3:0] timer,
  output logic       running,
  output logic       done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [3:0] raw_btn, lvl, prs;
  logic       tu_p, td_p, mu_p, md_p;

  assign raw_btn = {btn_time_down, btn_time_up, btn_temp_down, btn_temp_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    oven_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_btn[i]),
      .level (lvl[i]),
      .press (prs[i])
    );
  end

  // A press pulse always coincides with a high level.
  assign tu_p = prs[0] & lvl[0];
  assign td_p = prs[1] & lvl[1];
  assign mu_p = prs[2] & lvl[2];
  assign md_p = prs[3] & lvl[3];

  logic          start_s1_q, start_s2_q;
  logic          stop_s1_q, stop_s2_q;
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    timer_q, timer_d;
  logic [7:0]    temp_q, temp_d;
  logic [3:0]    stime_q, stime_d;
  logic [8:0]    sum;
  logic [3:0]    tnext;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    timer_d = timer_q;
    tnext   = timer_q + 4'd1;
    if (stop_s2_q) begin
      state_d = ST_IDLE;
      presc_d = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          timer_d = '0;
          if (start_s2_q) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (presc_q == P_LAST) begin
            presc_d = '0;
            timer_d = tnext;
            if (tnext >= stime_q) state_d = ST_DONE;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        ST_DONE: begin
          presc_d = '0;
          timer_d = stime_q;
          if (start_s2_q) begin
            state_d = ST_RUN;
            timer_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  // Sum in 9 bits and compare before subtracting so neither direction wraps.
  always_comb begin
    temp_d = temp_q;
    sum    = {1'b0, temp_q} + {1'b0, TEMP_STEP};
    if (tu_p && !td_p) begin
      temp_d = (sum > {1'b0, TEMP_MAX}) ? TEMP_MAX : sum[7:0];
    end else if (td_p && !tu_p) begin
      if ({1'b0, temp_q} < ({1'b0, TEMP_MIN} + {1'b0, TEMP_STEP}))
        temp_d = TEMP_MIN;
      else
        temp_d = temp_q - TEMP_STEP;
    end
  end

  always_comb begin
    stime_d = stime_q;
    if (state_q != ST_RUN) begin
      if (mu_p && !md_p && stime_q != 4'd15) stime_d = stime_q + 4'd1;
      if (md_p && !mu_p && stime_q > 4'd1)   stime_d = stime_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      stop_s1_q  <= 1'b0;
      stop_s2_q  <= 1'b0;
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      timer_q    <= '0;
      temp_q     <= TEMP_INIT;
      stime_q    <= TIME_INIT;
    end else begin
      start_s1_q <= start;
      start_s2_q <= start_s1_q;
      stop_s1_q  <= stop;
      stop_s2_q  <= stop_s1_q;
      state_q    <= state_d;
      presc_q    <= presc_d;
      timer_q    <= timer_d;
      temp_q     <= temp_d;
      stime_q    <= stime_d;
    end
  end

  assign set_temp  = temp_q;
  assign set_timer = stime_q;
  assign timer     = timer_q;
  assign running   = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_oven_setpoint_timer.sv
// Directed bench for oven_setpoint_timer with TICK_DIV=4, DEBOUNCE=3.
// A second instance starting at set_temp=12 covers the lower clamp.
module tb_oven_setpoint_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] btn = 4'b0;
  logic       b12_dn = 1'b0;

  logic [7:0] set_temp, set_temp12;
  logic [3:0] set_timer, timer, set_timer12, timer12;
  logic       running, done, running12, done12;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  oven_setpoint_timer #(.TICK_DIV(4), .DEBOUNCE(3)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .btn_temp_up   (btn[0]),
    .btn_temp_down (btn[1]),
    .btn_time_up   (btn[2]),
    .btn_time_down (btn[3]),
    .set_temp      (set_temp),
    .set_timer     (set_timer),
    .timer         (timer),
    .running       (running),
    .done          (done)
  );

  oven_setpoint_timer #(
    .TICK_DIV(4), .DEBOUNCE(3), .TEMP_INIT(8'd12)
  ) u_dut12 (
    .clk           (clk),
    .rst           (rst),
    .start         (1'b0),
    .stop          (1'b0),
    .btn_temp_up   (1'b0),
    .btn_temp_down (b12_dn),
    .btn_time_up   (1'b0),
    .btn_time_down (1'b0),
    .set_temp      (set_temp12),
    .set_timer     (set_timer12),
    .timer         (timer12),
    .running       (running12),
    .done          (done12)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    btn = m;
    cyc(hold);
    btn = 4'b0;
    cyc(10);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(3);
    checks++; if (set_temp !== 8'd100) begin errors++; $display("FAIL rst_temp got=%0d exp=100", set_temp); end
    checks++; if (set_timer !== 4'd5) begin errors++; $display("FAIL rst_stime got=%0d exp=5", set_timer); end
    checks++; if (timer !== 4'd0) begin errors++; $display("FAIL rst_timer got=%0d exp=0", timer); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got=%b exp=0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    rst = 1'b0;
    cyc(3);
    checks++; if (set_temp12 !== 8'd12) begin errors++; $display("FAIL rst_temp12 got=%0d exp=12", set_temp12); end
  endtask

  task automatic test_debounce;
    btn[0] = 1'b1;
    cyc(2);
    btn[0] = 1'b0;
    cyc(10);
    checks++; if (set_temp !== 8'd100) begin errors++; $display("FAIL glitch got=%0d exp=100", set_temp); end
    btn[0] = 1'b1;
    cyc(5);
    checks++; if (set_temp !== 8'd100) begin errors++; $display("FAIL press_early got=%0d exp=100", set_temp); end
    cyc(1);
    checks++; if (set_temp !== 8'd105) begin errors++; $display("FAIL press_step got=%0d exp=105", set_temp); end
    cyc(4);
    checks++; if (set_temp !== 8'd105) begin errors++; $display("FAIL press_hold got=%0d exp=105", set_temp); end
    btn[0] = 1'b0;
    cyc(10);
    for (int i = 0; i < 40; i++) press(4'b0001, 6);
    checks++; if (set_temp !== 8'd245) begin errors++; $display("FAIL temp_sat got=%0d exp=245", set_temp); end
    btn[1] = 1'b1;
    b12_dn = 1'b1;
    cyc(8);
    btn[1] = 1'b0;
    b12_dn = 1'b0;
    cyc(10);
    checks++; if (set_temp !== 8'd240) begin errors++; $display("FAIL temp_down got=%0d exp=240", set_temp); end
    checks++; if (set_temp12 !== 8'd10) begin errors++; $display("FAIL temp_min got=%0d exp=10", set_temp12); end
  endtask

  task automatic test_full_run;
    press(4'b1000, 6);
    press(4'b1000, 6);
    checks++; if (set_timer !== 4'd3) begin errors++; $display("FAIL stime_3 got=%0d exp=3", set_timer); end
    start = 1'b1;
    cyc(2);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_early got=%b exp=0", running); end
    cyc(1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_lat got=%b exp=1", running); end
    checks++; if (timer !== 4'd0) begin errors++; $display("FAIL run_t0 got=%0d exp=0", timer); end
    btn[2] = 1'b1;
    cyc(3);
    checks++; if (timer !== 4'd0) begin errors++; $display("FAIL run_t0b got=%0d exp=0", timer); end
    cyc(1);
    checks++; if (timer !== 4'd1) begin errors++; $display("FAIL run_t1 got=%0d exp=1", timer); end
    cyc(4);
    checks++; if (timer !== 4'd2) begin errors++; $display("FAIL run_t2 got=%0d exp=2", timer); end
    cyc(3);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_early got=%b exp=0", done); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_e11 got=%b exp=1", running); end
    cyc(1);
    btn[2] = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_e12 got=%b exp=1", done); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_off got=%b exp=0", running); end
    checks++; if (timer !== 4'd3) begin errors++; $display("FAIL done_t got=%0d exp=3", timer); end
    checks++; if (set_timer !== 4'd3) begin errors++; $display("FAIL run_lock got=%0d exp=3", set_timer); end
    cyc(1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL restart got=%b exp=1", running); end
    checks++; if (timer !== 4'd0) begin errors++; $display("FAIL restart_t got=%0d exp=0", timer); end
  endtask

  task automatic test_stop_vs_tick;
    cyc(4);
    checks++; if (timer !== 4'd1) begin errors++; $display("FAIL r2_t1 got=%0d exp=1", timer); end
    cyc(1);
    stop = 1'b1;
    cyc(2);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL stop_early got=%b exp=1", running); end
    checks++; if (timer !== 4'd1) begin errors++; $display("FAIL stop_pre_t got=%0d exp=1", timer); end
    cyc(1);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_run got=%b exp=0", running); end
    checks++; if (timer !== 4'd0) begin errors++; $display("FAIL stop_tick got=%0d exp=0", timer); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done got=%b exp=0", done); end
    cyc(5);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_hold got=%b exp=0", running); end
    start = 1'b0;
    cyc(3);
    stop = 1'b0;
    cyc(5);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_after got=%b exp=0", running); end
  endtask

  task automatic test_buttons;
    press(4'b1100, 6);
    checks++; if (set_timer !== 4'd3) begin errors++; $display("FAIL both_btn got=%0d exp=3", set_timer); end
    press(4'b1000, 6);
    press(4'b1000, 6);
    checks++; if (set_timer !== 4'd1) begin errors++; $display("FAIL stime_1 got=%0d exp=1", set_timer); end
    press(4'b1000, 6);
    checks++; if (set_timer !== 4'd1) begin errors++; $display("FAIL stime_min got=%0d exp=1", set_timer); end
    for (int i = 0; i < 14; i++) press(4'b0100, 6);
    checks++; if (set_timer !== 4'd15) begin errors++; $display("FAIL stime_15 got=%0d exp=15", set_timer); end
    press(4'b0100, 6);
    checks++; if (set_timer !== 4'd15) begin errors++; $display("FAIL stime_max got=%0d exp=15", set_timer); end
  endtask

  task automatic test_reset_mid_run;
    start = 1'b1;
    cyc(3);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL mr_run got=%b exp=1", running); end
    cyc(8);
    checks++; if (timer !== 4'd2) begin errors++; $display("FAIL mr_t2 got=%0d exp=2", timer); end
    rst = 1'b1;
    #1;
    checks++; if (set_temp !== 8'd100) begin errors++; $display("FAIL mr_temp got=%0d exp=100", set_temp); end
    checks++; if (set_timer !== 4'd5) begin errors++; $display("FAIL mr_stime got=%0d exp=5", set_timer); end
    checks++; if (timer !== 4'd0) begin errors++; $display("FAIL mr_timer got=%0d exp=0", timer); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL mr_running got=%b exp=0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mr_done got=%b exp=0", done); end
    start = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_full_run;
    test_stop_vs_tick;
    test_buttons;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
